// File: rtl/seg7_scan_to_bcd_pkg.sv
// seg7_defs: shared definitions for the 7-segment display interface.
//   SEG_DIGIT : active-high gfedcba patterns for digits 0..9 (same table the
//               encoder drives), index = BCD value.
//   SEG_BLANK : all segments dark.
//   state_t   : scan-receiver capture FSM states.
package seg7_defs;

    localparam logic [6:0] SEG_DIGIT [10] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };

    localparam logic [6:0] SEG_BLANK = 7'h00;

    typedef enum logic [1:0] {
        IDLE,
        TRACK,
        CAPTURED
    } state_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
// seg7_pattern_decode: combinational 7-segment pattern to BCD decoder.
// Ports:
//   pattern  in   7  active-high segments, [0]=a .. [6]=g
//   legal    out  1  pattern is one of the digits 0..9
//   blank    out  1  pattern is all segments dark
//   bcd      out  4  decoded value when legal, else 0
module seg7_pattern_decode
    import seg7_defs::*;
(
    input  logic [6:0] pattern,
    output logic       legal,
    output logic       blank,
    output logic [3:0] bcd
);

    always_comb begin
        legal = 1'b0;
        blank = (pattern == SEG_BLANK);
        bcd   = '0;
        for (int unsigned i = 0; i < 10; i++) begin
            if (pattern == SEG_DIGIT[i]) begin
                legal = 1'b1;
                bcd   = 4'(i);
            end
        end
    end

endmodule

// File: rtl/seg7_scan_to_bcd.sv
// seg7_scan_to_bcd: snoops a time-multiplexed 7-segment display bus and
// rebuilds the BCD value of every digit.
// Ports:
//   clk          in   1             system clock, rising edge
//   rst_n        in   1             asynchronous active-low reset
//   seg_in       in   7             segment lines, [0]=a .. [6]=g
//   an_in        in   NUM_DIGITS    digit enables, bit i = digit i
//   clr_err      in   1             synchronous clear of seg_err
//   bcd_out      out  4*NUM_DIGITS  digit i at [4i+3:4i]
//   digit_valid  out  NUM_DIGITS    last capture of digit i was a legal 0..9
//   frame_valid  out  1             pulse: every digit captured since last pulse
//   seg_err      out  NUM_DIGITS    sticky: digit i showed an illegal pattern
module seg7_scan_to_bcd
    import seg7_defs::*;
#(
    parameter int unsigned NUM_DIGITS    = 4,
    parameter int unsigned STABLE_CYCLES = 3,
    parameter int unsigned SEG_ACT_LOW   = 1,
    parameter int unsigned AN_ACT_LOW    = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [6:0]                seg_in,
    input  logic [NUM_DIGITS-1:0]     an_in,
    input  logic                      clr_err,
    output logic [4*NUM_DIGITS-1:0]   bcd_out,
    output logic [NUM_DIGITS-1:0]     digit_valid,
    output logic                      frame_valid,
    output logic [NUM_DIGITS-1:0]     seg_err
);

    localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);
    localparam int unsigned SW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    // Synchronisers reset to the bus idle level so reset never looks like a slot.
    localparam logic [NUM_DIGITS-1:0] AN_IDLE  = (AN_ACT_LOW != 0) ? '1 : '0;
    localparam logic [6:0]            SEG_IDLE = (SEG_ACT_LOW != 0) ? '1 : '0;

    logic [1:0]            rst_pipe;
    logic                  rst_int;
    logic [6:0]            seg_meta, seg_sync, seg_n;
    logic [NUM_DIGITS-1:0] an_meta, an_sync, an_n;
    logic                  slot_ok;
    logic [SW-1:0]         slot_idx;
    state_t                state;
    logic [CW-1:0]         cnt;
    logic [SW-1:0]         cur_slot;
    logic [6:0]            cur_seg;
    logic                  same;
    logic                  cap;
    logic                  dec_legal, dec_blank;
    logic [3:0]            dec_bcd;
    logic [NUM_DIGITS-1:0] cap_bits, err_bits, mask, mask_next;

    // Reset: asserts asynchronously, releases synchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_pipe <= '0;
        else        rst_pipe <= {rst_pipe[0], 1'b1};
    end
    assign rst_int = rst_pipe[1];

    always_ff @(posedge clk or negedge rst_int) begin
        if (!rst_int) begin
            seg_meta <= SEG_IDLE;
            seg_sync <= SEG_IDLE;
            an_meta  <= AN_IDLE;
            an_sync  <= AN_IDLE;
        end else begin
            seg_meta <= seg_in;
            seg_sync <= seg_meta;
            an_meta  <= an_in;
            an_sync  <= an_meta;
        end
    end

    assign seg_n = (SEG_ACT_LOW != 0) ? ~seg_sync : seg_sync;
    assign an_n  = (AN_ACT_LOW != 0)  ? ~an_sync  : an_sync;

    // Exactly one enable set gives a slot; overlap or none is no slot.
    always_comb begin
        slot_ok  = (an_n != '0) && ((an_n & (an_n - NUM_DIGITS'(1))) == '0);
        slot_idx = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (an_n[i]) slot_idx = SW'(i);
        end
    end

    assign same = (slot_idx == cur_slot) && (seg_n == cur_seg);
    assign cap  = (state == TRACK) && (cnt == CW'(STABLE_CYCLES));

    seg7_pattern_decode u_decode (
        .pattern (cur_seg),
        .legal   (dec_legal),
        .blank   (dec_blank),
        .bcd     (dec_bcd)
    );

    always_comb begin
        cap_bits = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            cap_bits[i] = cap && (cur_slot == SW'(i));
        end
        err_bits  = cap_bits & {NUM_DIGITS{!dec_legal && !dec_blank}};
        // A full mask is held for exactly the frame_valid cycle, then restarts.
        mask_next = ((&mask) ? '0 : mask) | cap_bits;
    end

    always_ff @(posedge clk or negedge rst_int) begin
        if (!rst_int) begin
            state       <= IDLE;
            cnt         <= '0;
            cur_slot    <= '0;
            cur_seg     <= '0;
            bcd_out     <= '0;
            digit_valid <= '0;
            frame_valid <= 1'b0;
            seg_err     <= '0;
            mask        <= '0;
        end else begin
            mask        <= mask_next;
            frame_valid <= &mask_next;
            seg_err     <= (clr_err ? '0 : seg_err) | err_bits;

            for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                if (cap_bits[i]) begin
                    if (dec_legal) bcd_out[4*i +: 4] <= dec_bcd;
                    digit_valid[i] <= dec_legal;
                end
            end

            // The capture uses the stored sample; the current sample still
            // decides the next state so a change on the capture edge is tracked.
            case (state)
                IDLE: begin
                    if (slot_ok) begin
                        state    <= TRACK;
                        cnt      <= CW'(1);
                        cur_slot <= slot_idx;
                        cur_seg  <= seg_n;
                    end
                end
                default: begin
                    if (!slot_ok) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (!same) begin
                        state    <= TRACK;
                        cnt      <= CW'(1);
                        cur_slot <= slot_idx;
                        cur_seg  <= seg_n;
                    end else if (state == TRACK) begin
                        if (cap) state <= CAPTURED;
                        else     cnt   <= cnt + CW'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seg7_scan_to_bcd.sv
module tb_seg7_scan_to_bcd;

    localparam int STABLE = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic [6:0]  seg0;
    logic [3:0]  an0;
    logic        clr0;
    logic [15:0] bcd0;
    logic [3:0]  dv0;
    logic        fv0;
    logic [3:0]  err0;

    logic [6:0]  seg1;
    logic [1:0]  an1;
    logic        clr1;
    logic [7:0]  bcd1;
    logic [1:0]  dv1;
    logic        fv1;
    logic [1:0]  err1;

    always #5 clk = ~clk;

    seg7_scan_to_bcd #(
        .NUM_DIGITS(4), .STABLE_CYCLES(STABLE), .SEG_ACT_LOW(1), .AN_ACT_LOW(1)
    ) u0 (
        .clk(clk), .rst_n(rst_n), .seg_in(seg0), .an_in(an0), .clr_err(clr0),
        .bcd_out(bcd0), .digit_valid(dv0), .frame_valid(fv0), .seg_err(err0)
    );

    seg7_scan_to_bcd #(
        .NUM_DIGITS(2), .STABLE_CYCLES(STABLE), .SEG_ACT_LOW(0), .AN_ACT_LOW(0)
    ) u1 (
        .clk(clk), .rst_n(rst_n), .seg_in(seg1), .an_in(an1), .clr_err(clr1),
        .bcd_out(bcd1), .digit_valid(dv1), .frame_valid(fv1), .seg_err(err1)
    );

    int n_asserts = 0;
    int n_fail    = 0;
    int frames0   = 0;
    int frames1   = 0;

    always @(negedge clk) begin
        if (fv0 === 1'b1) frames0++;
        if (fv1 === 1'b1) frames1++;
    end

    // Reference: active-high gfedcba per digit value.
    logic [6:0] pat [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                             7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    int         exp_dig [4];
    logic [3:0] exp_dv, exp_err, exp_mask;
    int         exp_frames = 0;
    bit         run_valid;
    logic [3:0] run_an;
    logic [6:0] run_pat;
    int         run_len;
    bit         run_cap;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) exp_dig[i] = 0;
        exp_dv    = '0;
        exp_err   = '0;
        exp_mask  = '0;
        run_valid = 1'b0;
        run_len   = 0;
        run_cap   = 1'b0;
    endfunction

    // 0..9 digit, 10 blank, 11 illegal
    function automatic int decode(input logic [6:0] p);
        if (p == 7'h00) return 10;
        for (int v = 0; v < 10; v++) if (pat[v] == p) return v;
        return 11;
    endfunction

    function automatic void apply(input int d, input logic [6:0] p);
        int v = decode(p);
        exp_mask[d] = 1'b1;
        if (v < 10) begin
            exp_dig[d] = v;
            exp_dv[d]  = 1'b1;
        end else begin
            exp_dv[d] = 1'b0;
            if (v == 11) exp_err[d] = 1'b1;
        end
        if (exp_mask == 4'hF) begin
            exp_frames++;
            exp_mask = '0;
        end
    endfunction

    // A stable run of one digit enable captures once after STABLE cycles.
    function automatic void note_run(input logic [3:0] an, input logic [6:0] p, input int len);
        if (run_valid && an == run_an && p == run_pat) begin
            run_len += len;
        end else begin
            run_valid = 1'b1;
            run_an    = an;
            run_pat   = p;
            run_len   = len;
            run_cap   = 1'b0;
        end
        if ($countones(an) == 1 && !run_cap && run_len >= STABLE) begin
            run_cap = 1'b1;
            for (int i = 0; i < 4; i++) if (an[i]) apply(i, p);
        end
    endfunction

    function automatic logic [15:0] exp_bcd();
        logic [15:0] r;
        for (int i = 0; i < 4; i++) r[4*i +: 4] = 4'(exp_dig[i]);
        return r;
    endfunction

    // an/p are active-high; pins of u0 are active-low.
    task automatic hold(input logic [3:0] an, input logic [6:0] p, input int len);
        an0  = ~an;
        seg0 = ~p;
        repeat (len) @(posedge clk);
        #1;
        note_run(an, p, len);
    endtask

    task automatic checkpoint(input string tag);
        hold(4'b0000, 7'h00, 8);
        check({tag, "_bcd"},    32'(bcd0),    32'(exp_bcd()));
        check({tag, "_dv"},     32'(dv0),     32'(exp_dv));
        check({tag, "_err"},    32'(err0),    32'(exp_err));
        check({tag, "_frames"}, 32'(frames0), 32'(exp_frames));
    endtask

    initial begin
        an0 = '1; seg0 = '1; clr0 = 1'b0;
        an1 = '0; seg1 = '0; clr1 = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Reset in the middle of a scan
        hold(4'b0001, pat[7], 6);
        hold(4'b0010, pat[2], 2);
        rst_n = 1'b0;
        #1;
        check("rst_bcd", 32'(bcd0), 32'h0);
        check("rst_dv",  32'(dv0),  32'h0);
        check("rst_fv",  32'(fv0),  32'h0);
        check("rst_err", 32'(err0), 32'h0);
        model_reset();
        an0 = '1; seg0 = '1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        hold(4'b0000, 7'h00, 4);

        hold(4'b0001, pat[3], 4);
        hold(4'b0010, pat[1], 4);
        hold(4'b0100, pat[4], 4);
        hold(4'b1000, pat[1], 4);
        checkpoint("scan3141");
        check("scan3141_const", 32'(bcd0), 32'h1413);
        check("scan3141_dvF",   32'(dv0),  32'hF);

        // Latency: visible at edge t+5, not before
        an0  = 4'b1110;
        seg0 = ~7'h7F;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk);
            #1;
            check("lat_early", 32'(bcd0[3:0]), 32'd3);
        end
        @(posedge clk);
        #1;
        check("lat_t5", 32'(bcd0[3:0]), 32'd8);
        note_run(4'b0001, 7'h7F, 6);

        // Short dwell must not capture or touch the mask
        hold(4'b0010, pat[7], 2);
        checkpoint("short");
        hold(4'b0100, pat[6], 4);
        hold(4'b1000, pat[6], 4);
        checkpoint("after_short");
        hold(4'b0010, pat[2], 3);
        checkpoint("frame_after_short");

        // Illegal pattern on digit 2
        hold(4'b0100, 7'h49, 4);
        checkpoint("illegal");
        check("illegal_nib", 32'(bcd0[11:8]), 32'd6);
        an0  = ~4'b0100;
        seg0 = ~7'h49;
        repeat (5) @(posedge clk);
        #1;
        clr0 = 1'b1;
        @(posedge clk);
        #1;
        clr0 = 1'b0;
        note_run(4'b0100, 7'h49, 6);
        check("clr_vs_set", 32'(err0), 32'h4);
        hold(4'b0000, 7'h00, 2);
        clr0 = 1'b1;
        @(posedge clk);
        #1;
        clr0 = 1'b0;
        exp_err = '0;
        check("clr_only", 32'(err0), 32'h0);

        // Blank digit and anode overlap
        hold(4'b0001, 7'h00, 4);
        checkpoint("blank");
        hold(4'b0011, pat[5], 4);
        checkpoint("overlap");

        // Random scans against the model
        for (int b = 0; b < 12; b++) begin
            for (int d = 0; d < 5; d++) begin
                logic [3:0] a;
                logic [6:0] p;
                int r;
                r = $urandom_range(0, 9);
                if (r <= 6)      a = 4'(1 << $urandom_range(0, 3));
                else if (r <= 8) a = 4'b0000;
                else             a = 4'($urandom_range(0, 15));
                r = $urandom_range(0, 9);
                if (r <= 6)      p = pat[$urandom_range(0, 9)];
                else if (r == 7) p = 7'h00;
                else             p = 7'($urandom);
                hold(a, p, $urandom_range(1, 5));
            end
            checkpoint("rand");
        end

        // Active-high polarity, two digits
        check("pol_idle_frames", 32'(frames1), 32'd0);
        for (int s = 0; s < 3; s++) begin
            an1 = 2'b01; seg1 = 7'h6F;
            repeat (4) @(posedge clk);
            #1;
            an1 = 2'b10; seg1 = 7'h3F;
            repeat (4) @(posedge clk);
            #1;
        end
        an1 = 2'b00; seg1 = 7'h00;
        repeat (8) @(posedge clk);
        #1;
        check("pol_bcd",    32'(bcd1),    32'h09);
        check("pol_dv",     32'(dv1),     32'h3);
        check("pol_err",    32'(err1),    32'h0);
        check("pol_frames", 32'(frames1), 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
